// File: rtl/block_multiply_pkg.sv
// rtl/block_multiply_pkg.sv - shared defaults, accumulator width, FSM states and row-major index helpers
package block_multiply_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_J      = 2;
  localparam int DEF_K      = 2;

  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k);
  endfunction

  localparam int DEF_ACC_W = acc_width(DEF_DATA_W, DEF_K);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DONE  = 2'd2,
    REARM = 2'd3
  } state_t;

  function automatic int idx_rm(input int row, input int col, input int ncols);
    return row * ncols + col;
  endfunction

  function automatic int idx_a(input int row, input int k, input int kdim);
    return idx_rm(row, k, kdim);
  endfunction

  function automatic int idx_b(input int k, input int col, input int jdim);
    return idx_rm(k, col, jdim);
  endfunction

endpackage

// File: rtl/block_multiply_mac.sv
// rtl/block_multiply_mac.sv - signed multiply-accumulate with wrap or clamp output (BLOCK_MULTIPLY_SATURATE_EN)
module block_mac
  import block_multiply_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_last,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result
);

`ifdef BLOCK_MULTIPLY_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  logic signed [ACC_W-1:0]    r_acc;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_sum;
  logic                       w_hi;
  logic                       w_lo;

  assign w_prod = $signed(i_a) * $signed(i_b);
  assign w_sum  = r_acc + ACC_W'(w_prod);
  assign w_hi   = (w_sum > MAXV);
  assign w_lo   = (w_sum < MINV);

  // The result presented is acc+product so the last term lands on the same edge it is written.
  always_comb begin
    o_result = w_sum[DATA_W-1:0];
    if (SAT_EN && w_hi) o_result = MAXV[DATA_W-1:0];
    if (SAT_EN && w_lo) o_result = MINV[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_acc <= '0;
    else if (i_clr)  r_acc <= '0;
    else if (i_en)   r_acc <= i_last ? '0 : w_sum;
  end

endmodule

// File: rtl/block_multiply.sv
// rtl/block_multiply.sv - J x K by K x J block product, one MAC per cycle; optional BLOCK_MULTIPLY_SATURATE_EN clamp
module block_multiply
  import block_multiply_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int J      = DEF_J,
  parameter int K      = DEF_K
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [J*K*DATA_W-1:0]   block_a,
  input  logic [K*J*DATA_W-1:0]   block_b,
  output logic [J*J*DATA_W-1:0]   block_p,
  output logic                    busy,
  output logic                    done
);

  localparam int ACC_W = acc_width(DATA_W, K);
  localparam int RW    = (J > 1) ? $clog2(J) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  state_t                  r_state;
  logic [RW-1:0]           r_row;
  logic [RW-1:0]           r_col;
  logic [KW-1:0]           r_k;
  logic [J*K*DATA_W-1:0]   r_a;
  logic [K*J*DATA_W-1:0]   r_b;
  logic [J*J*DATA_W-1:0]   r_p;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_accept;
  logic                    w_mac_en;
  logic                    w_last;
  logic                    w_col_last;
  logic                    w_row_last;
  logic [DATA_W-1:0]       w_a;
  logic [DATA_W-1:0]       w_b;
  logic [DATA_W-1:0]       w_result;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_mac_en   = (r_state == MAC);
  assign w_last     = (r_k   == KW'(K - 1));
  assign w_col_last = (r_col == RW'(J - 1));
  assign w_row_last = (r_row == RW'(J - 1));

  // Operands always come from the copies taken at accept, never the live inputs.
  assign w_a = r_a[idx_a(int'(r_row), int'(r_k), K) * DATA_W +: DATA_W];
  assign w_b = r_b[idx_b(int'(r_k), int'(r_col), J) * DATA_W +: DATA_W];

  block_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_accept),
    .i_en     (w_mac_en),
    .i_last   (w_last),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= block_a;
            r_b     <= block_b;
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= MAC;
          end
        end
        MAC: begin
          if (w_last) begin
            r_p[idx_rm(int'(r_row), int'(r_col), J) * DATA_W +: DATA_W] <= w_result;
            r_k <= '0;
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                r_row   <= '0;
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= REARM;
        end
        REARM: begin
          // A start still held from the finished run must drop before a new accept.
          if (!start) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign block_p = r_p;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_block_multiply.sv
// tb/tb_block_multiply.sv - self-checking bench for block_multiply (J=K=2, DATA_W=16)
module tb_block_multiply;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] block_a;
  logic [63:0] block_b;
  logic [63:0] block_p;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  logic [63:0] sb[$];

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] p;
    bit          hold;
    string       nm;
  } vec_t;

  block_multiply #(.DATA_W(16), .J(2), .K(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .block_a (block_a),
    .block_b (block_b),
    .block_p (block_p),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_p(input string nm, input logic [63:0] exp);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_p%0d", nm, i), int'($signed(block_p[i*16 +: 16])), int'($signed(exp[i*16 +: 16])));
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b, input logic [63:0] p,
                     input bit hold, input bit chg, input string nm);
    int n;
    int extra;
    logic [63:0] exp;
    @(negedge clk);
    block_a = a;
    block_b = b;
    start   = 1'b1;
    sb.push_back(p);
    @(posedge clk); #1;
    chk({nm, "_busy_accept"}, int'(busy), 1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (chg && n == 1) block_a = {4{16'd9}};
    end
    chk({nm, "_done_latency"}, n, 8);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    chk_p(nm, exp);
    if (hold) begin
      extra = 0;
      repeat (10) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      chk({nm, "_no_second_done"}, extra, 0);
      chk({nm, "_busy_rearm"}, int'(busy), 0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  vec_t tbl[4];

  initial begin
    int dn;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    block_a = '0;
    block_b = '0;

    tbl[0] = '{pack4(1, 2, 3, 4), pack4(1, 0, 0, 1), pack4(1, 2, 3, 4), 1'b1, "ident"};
    tbl[1] = '{pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), pack4(19, 22, 43, 50), 1'b0, "basic"};
    tbl[2] = '{pack4(-3, 0, 0, -1), pack4(2, 5, 7, -4), pack4(-6, -15, -7, 4), 1'b0, "neg"};
`ifdef BLOCK_MULTIPLY_SATURATE_EN
    tbl[3] = '{pack4(16384, 16384, 0, 0), pack4(2, 0, 2, 0), pack4(32767, 0, 0, 0), 1'b0, "ovf"};
`else
    tbl[3] = '{pack4(16384, 16384, 0, 0), pack4(2, 0, 2, 0), pack4(0, 0, 0, 0), 1'b0, "ovf"};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_p", int'(block_p == 64'd0), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].hold, 1'b0, tbl[i].nm);

    // Abort a run with reset four edges after accept.
    @(negedge clk);
    block_a = pack4(1, 2, 3, 4);
    block_b = pack4(5, 6, 7, 8);
    start   = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("abort_p_nonzero_before", int'(block_p != 64'd0), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);

    run(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), pack4(19, 22, 43, 50), 1'b0, 1'b0, "after_rst");
    run(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), pack4(19, 22, 43, 50), 1'b0, 1'b1, "a_change");

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
